mux_rr_n: RTL

- Parametrised N-channel, WIDTH-bit successor to the 2:1 datapath mux in the ALU lab.
- Selects one of N valid/ready input channels and delivers the word through a registered output stage with valid/ready handshake.
- Two selection modes:
  - fixed select (a direct generalisation of the S-controlled mux);
  - fair round-robin arbitration.
- Sits between operand sources and the ALU input register.

---
 rtl/alu_pkg.sv | 12 +
 rtl/mux_rr_n_if.sv | 26 ++
 rtl/mux_rr_n_arb.sv | 27 ++
 rtl/mux_rr_n.sv | 83 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-path blocks: default word width and mux mode encodings.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N     = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_rr_n_if.sv
// Channel-side and output-side handshake bundle of mux_rr_n; slave is the mux, master is the surrounding logic.
interface mux_rr_n_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/mux_rr_n_arb.sv
// Rotating-priority one-hot grant: searches i_last+1, i_last+2, ... modulo N for the first request.
// Purely combinational, zero latency; no state, no backpressure.
module rr_arbiter_n #(
    parameter int N = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_last,
    output logic [N-1:0]     o_gnt
);

    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(i_last) + k) % N;
            if (!w_found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel valid/ready mux (fixed select or round-robin) into a single registered output stage.
// Latency 1 cycle, 1 word/cycle sustained; a held word with out_ready low stalls every channel.
module mux_rr_n
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    localparam int SEL_W = $clog2(N)
) (
    input logic      clk,
    input logic      rst,
    mux_rr_n_if.slave bus
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_last;

    logic             w_load;
    logic             w_sel_ok;
    logic [N-1:0]     w_fix_gnt;
    logic [N-1:0]     w_rr_gnt;
    logic [N-1:0]     w_gnt;
    logic [SEL_W-1:0] w_src;
    logic [WIDTH-1:0] w_word;

    assign w_load   = !r_out_valid || bus.out_ready;
    // Zero-extended compare keeps the range check meaningful when N is not a power of two.
    assign w_sel_ok = ({1'b0, bus.sel} < (SEL_W+1)'(N));

    always_comb begin
        w_fix_gnt = '0;
        for (int i = 0; i < N; i++) begin
            w_fix_gnt[i] = w_sel_ok && (bus.sel == SEL_W'(i)) && bus.in_valid[i];
        end
    end

    rr_arbiter_n #(.N(N)) u_arb (
        .i_req  (bus.in_valid),
        .i_last (r_last),
        .o_gnt  (w_rr_gnt)
    );

    assign w_gnt = (mode_e'(bus.mode) == MODE_RR) ? w_rr_gnt : w_fix_gnt;

    always_comb begin
        w_src  = '0;
        w_word = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_src = SEL_W'(i);
            end
            w_word = w_word | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
        end
    end

    // Reset also masks ready so no channel believes its word was taken during a reset cycle.
    assign bus.in_ready = (w_load && !rst) ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= SEL_W'(N-1);
        end else if (w_load) begin
            if (|w_gnt) begin
                r_out_data  <= w_word;
                r_out_src   <= w_src;
                r_out_valid <= 1'b1;
                r_last      <= w_src;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;

endmodule
